circuito_jogo_param: RTL
========================

CIRCUITO_JOGO_PARAM -- requirements
Module: circuito_jogo_param

Interface
REQ-001 Parameter N, default 4, number of player keys and width of sequence entries.
REQ-002 Parameter DEPTH, default 16, maximum sequence length (rounds), power of two, 2..256.
REQ-003 Parameter TIMEOUT_CYC, default 5000, clock cycles allowed per move.
REQ-004 clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 iniciar  in  1  start/restart request, level-sampled.
REQ-007 chaves  in  N  player keys; a move is any nonzero value.
REQ-008 acertou / errou / pronto  out  1 each  game-won / game-lost / game-finished flags.
REQ-009 leds  out  N  combinational copy of chaves.
REQ-010 db_estado  out  4  current state code.
REQ-011 db_rodada, db_contagem  out  clog2(DEPTH) each  current round index and move index within the round.
REQ-012 db_memoria, db_jogada  out  N each  expected entry and last registered move.
REQ-013 db_igual, db_timeout, db_tem_jogada  out  1 each  compare result, timeout flag, chaves nonzero.

Function
REQ-014 The block SHALL be a Moore FSM with states inicial=0, preparacao=1, espera=2, registra=4, comparacao=5, proxima_jogada=6, proxima_rodada=7, fim_acerto=A, fim_erro=E, fim_timeout=D (hex), emitted on db_estado.
REQ-015 inicial SHALL go to preparacao on the cycle after iniciar=1, otherwise hold.
REQ-016 preparacao SHALL zero rodada, contagem, timeout counter and jogada register, then go to espera after one cycle.
REQ-017 A move event (jogada_feita) SHALL be a one-cycle pulse when chaves goes from all-zero to nonzero (registered edge detect); held keys SHALL produce exactly one event.
REQ-018 espera SHALL go to registra on jogada_feita; registra SHALL latch chaves into the jogada register and go to comparacao.
REQ-019 comparacao: mismatch -> fim_erro; match and contagem<rodada -> proxima_jogada; match, contagem==rodada, rodada<DEPTH-1 -> proxima_rodada; match, contagem==rodada==DEPTH-1 -> fim_acerto.
REQ-020 proxima_jogada SHALL increment contagem; proxima_rodada SHALL increment rodada and zero contagem; both return to espera next cycle.
REQ-021 The timeout counter SHALL count only in espera, zero on leaving espera, and on reaching TIMEOUT_CYC-1 move the FSM to fim_timeout.
REQ-022 If jogada_feita and timeout expiry coincide, the move SHALL take priority.
REQ-023 pronto SHALL be 1 in all fim states; acertou only in fim_acerto; errou in fim_erro and fim_timeout; db_timeout only in fim_timeout.
REQ-024 fim states SHALL hold all counters and outputs until iniciar=1, then go to preparacao.
REQ-025 Move latency: registra one cycle after edge, comparison result visible one cycle later.
REQ-026 Counters SHALL never wrap; rodada saturates at DEPTH-1 by construction of REQ-019.

Reset
REQ-027 reset SHALL force inicial, zero all counters and registers, and drive acertou=errou=pronto=db_timeout=0, taking priority over every other input, including mid-game.

Configuration
REQ-028 With CIRCUITO_JOGO_TIMEOUT_EN defined, REQ-021/022 apply; without it, the timeout counter SHALL not be built, fim_timeout SHALL be unreachable and db_timeout tied 0.

Structure
REQ-029 State codes, width function and default sequence function (entry i = one-hot bit i mod N) SHALL live in package jogo_pkg.
REQ-030 Sequence storage SHALL be a sub-module sync_rom_sequencia (DEPTH x N, synchronous read, address=contagem, contents from jogo_pkg).

Verification
REQ-031 Reset mid-espera at rodada=3 -> next cycle db_estado=0, db_rodada=0, pronto=0.
REQ-032 Defaults, iniciar, play 0001 -> proxima_rodada, db_rodada=1; then 0001,0010 -> db_rodada=2.
REQ-033 Round 0, play 0100 -> fim_erro, errou=1, pronto=1, db_jogada=0100.
REQ-034 Full 16-round correct game -> fim_acerto, acertou=1, db_rodada=15, db_contagem=15.
REQ-035 TIMEOUT_EN, no keys for 5000 cycles in espera -> fim_timeout, errou=1, db_timeout=1; key on expiry cycle -> registra instead.
REQ-036 Hold chaves=0001 for 50 cycles in espera -> exactly one registra visit.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game: state codes, width helper and default sequence.
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        ESPERA         = 4'h2,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    // Bits needed to index 'value' entries; never below 1 so ports stay legal.
    function automatic int width_of(input int value);
        if (value <= 2) begin
            return 1;
        end
        return $clog2(value);
    endfunction

    // Default sequence: entry i lights key (i mod n).
    function automatic logic [31:0] seq_entry(input int idx, input int n);
        return 32'd1 << (idx % n);
    endfunction

endpackage

// File: rtl/circuito_jogo_param_if.sv
// Player-facing and debug signals of circuito_jogo_param; the environment holds master, the game holds slave.
interface circuito_jogo_param_if
    import jogo_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 16
);
    localparam int AW = width_of(DEPTH);

    // No valid/ready pair: iniciar is level-sampled every cycle, and a move is the
    // all-zero -> nonzero transition of chaves; keys may be held, only the edge counts.
    logic          iniciar;
    logic [N-1:0]  chaves;
    logic          acertou;
    logic          errou;
    logic          pronto;
    logic [N-1:0]  leds;
    logic [3:0]    db_estado;
    logic [AW-1:0] db_rodada;
    logic [AW-1:0] db_contagem;
    logic [N-1:0]  db_memoria;
    logic [N-1:0]  db_jogada;
    logic          db_igual;
    logic          db_timeout;
    logic          db_tem_jogada;

    modport master (
        output iniciar, chaves,
        input  acertou, errou, pronto, leds, db_estado, db_rodada, db_contagem,
        input  db_memoria, db_jogada, db_igual, db_timeout, db_tem_jogada
    );

    modport slave (
        input  iniciar, chaves,
        output acertou, errou, pronto, leds, db_estado, db_rodada, db_contagem,
        output db_memoria, db_jogada, db_igual, db_timeout, db_tem_jogada
    );

endinterface

// File: rtl/sync_rom_sequencia.sv
// DEPTH x N sequence ROM with one-cycle registered read; contents come from jogo_pkg::seq_entry.
module sync_rom_sequencia
    import jogo_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 16,
    parameter int AW    = width_of(DEPTH)
) (
    input  logic          clock,
    input  logic [AW-1:0] endereco,
    output logic [N-1:0]  dado
);

    logic [N-1:0] palavra;

    always_comb begin
        palavra = N'(seq_entry(int'(endereco), N));
    end

    always_ff @(posedge clock) begin
        dado <= palavra;
    end

endmodule

// File: rtl/circuito_jogo_param.sv
// Memory game FSM: the player repeats a growing key sequence. Optional move timeout is
// built only when CIRCUITO_JOGO_TIMEOUT_EN is defined.
module circuito_jogo_param
    import jogo_pkg::*;
#(
    parameter int N           = 4,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                  clock,
    input  logic                  reset,
    circuito_jogo_param_if.slave  bus
);

    localparam int            AW     = width_of(DEPTH);
    localparam logic [AW-1:0] ULTIMA = AW'(DEPTH - 1);

    estado_t       estado, proximo;
    logic [AW-1:0] rodada, contagem;
    logic [N-1:0]  jogada, memoria;
    logic          tem_jogada, tem_jogada_q, jogada_feita, igual, expirou;

    assign tem_jogada   = |bus.chaves;
    assign jogada_feita = tem_jogada & ~tem_jogada_q;
    assign igual        = (jogada == memoria);

    sync_rom_sequencia #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_rom (
        .clock    (clock),
        .endereco (contagem),
        .dado     (memoria)
    );

`ifdef CIRCUITO_JOGO_TIMEOUT_EN
    localparam int TW = width_of(TIMEOUT_CYC);
    logic [TW-1:0] tempo;

    // Counter restarts whenever the FSM is not staying in espera.
    always_ff @(posedge clock) begin
        if (reset || !(estado == ESPERA && proximo == ESPERA)) begin
            tempo <= '0;
        end else begin
            tempo <= tempo + 1'b1;
        end
    end

    assign expirou = (estado == ESPERA) && (tempo == TW'(TIMEOUT_CYC - 1));
`else
    assign expirou = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:        if (bus.iniciar) proximo = PREPARACAO;
            PREPARACAO:     proximo = ESPERA;
            // A move wins over a coinciding expiry.
            ESPERA: begin
                if (jogada_feita)  proximo = REGISTRA;
                else if (expirou)  proximo = FIM_TIMEOUT;
            end
            REGISTRA:       proximo = COMPARACAO;
            COMPARACAO: begin
                if (!igual)                   proximo = FIM_ERRO;
                else if (contagem < rodada)   proximo = PROXIMA_JOGADA;
                else if (rodada < ULTIMA)     proximo = PROXIMA_RODADA;
                else                          proximo = FIM_ACERTO;
            end
            PROXIMA_JOGADA: proximo = ESPERA;
            PROXIMA_RODADA: proximo = ESPERA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (bus.iniciar) proximo = PREPARACAO;
            end
            default:        proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rodada       <= '0;
            contagem     <= '0;
            jogada       <= '0;
            tem_jogada_q <= 1'b0;
        end else begin
            tem_jogada_q <= tem_jogada;
            case (estado)
                PREPARACAO: begin
                    rodada   <= '0;
                    contagem <= '0;
                    jogada   <= '0;
                end
                REGISTRA:       jogada   <= bus.chaves;
                PROXIMA_JOGADA: contagem <= contagem + 1'b1;
                PROXIMA_RODADA: begin
                    rodada   <= rodada + 1'b1;
                    contagem <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.pronto        = (estado == FIM_ACERTO) || (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
    assign bus.acertou       = (estado == FIM_ACERTO);
    assign bus.errou         = (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
    assign bus.leds          = bus.chaves;
    assign bus.db_estado     = estado;
    assign bus.db_rodada     = rodada;
    assign bus.db_contagem   = contagem;
    assign bus.db_memoria    = memoria;
    assign bus.db_jogada     = jogada;
    assign bus.db_igual      = igual;
    assign bus.db_tem_jogada = tem_jogada;
`ifdef CIRCUITO_JOGO_TIMEOUT_EN
    assign bus.db_timeout    = (estado == FIM_TIMEOUT);
`else
    assign bus.db_timeout    = 1'b0;
`endif

endmodule
